instr_fetch: RTL

Instruction fetch sequencer for the OSECPU core. It reads 32-bit code words from synchronous program memory and assembles one- or two-word instructions into `instr0`/`instr1`. It drives the `current_state` bus that the datapath decodes, and holds `STATE_EXEC` for exactly as long as the datapath and MMU need. It owns the program counter and applies jump targets returned from the execute stage.

---
 rtl/instr_fetch.sv | 133 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// OSECPU instruction fetch sequencer: builds 1/2-word instructions from synchronous code memory.
// Optional fetch/jump bounds checking is compiled in with `define FETCH_BOUNDS_EN.
module instr_fetch #(
  parameter int PC_W       = 16,
  parameter int CODE_WORDS = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic [PC_W-1:0] mem_addr,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     instr0,
  output logic [31:0]     instr1,
  output logic [3:0]      current_state,
  output logic [PC_W-1:0] pc,
  input  logic            exec_stall,
  input  logic            jmp_req,
  input  logic [PC_W-1:0] jmp_addr,
  output logic            halted,
  output logic            fault
);

  localparam logic [2:0] S_HLT   = 3'd0;
  localparam logic [2:0] S_F0    = 3'd1;
  localparam logic [2:0] S_F0W   = 3'd2;
  localparam logic [2:0] S_F1    = 3'd3;
  localparam logic [2:0] S_F1W   = 3'd4;
  localparam logic [2:0] S_EXEC  = 3'd5;

  localparam logic [7:0] OP_LBSET  = 8'h01;
  localparam logic [7:0] OP_LIMM32 = 8'h03;
  localparam logic [7:0] OP_END    = 8'hFF;

  if (CODE_WORDS < 1 || PC_W < 1) begin : g_bad_cfg
    $error("instr_fetch: CODE_WORDS and PC_W must be positive");
  end

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr0_q, instr0_d, instr1_q, instr1_d;
  logic            flt;
  logic            two_word;

  assign two_word = (mem_rdata[31:24] == OP_LIMM32) || (mem_rdata[31:24] == OP_LBSET);

`ifdef FETCH_BOUNDS_EN
  localparam logic [PC_W:0] CODE_LIM = (PC_W+1)'(CODE_WORDS);
  logic fault_q, fault_d;
  assign flt = fault_q;
`else
  assign flt = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
`ifdef FETCH_BOUNDS_EN
    fault_d  = fault_q;
`endif
    case (state_q)
      S_HLT:  if (run && !flt) state_d = S_F0;
      S_F0:   state_d = S_F0W;
      S_F0W: begin
        instr0_d = mem_rdata;
        pc_d     = pc_q + PC_W'(1);
        if (two_word) state_d = S_F1;
        else begin
          instr1_d = 32'd0;
          state_d  = S_EXEC;
        end
      end
      S_F1:   state_d = S_F1W;
      S_F1W: begin
        instr1_d = mem_rdata;
        pc_d     = pc_q + PC_W'(1);
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        // run is only looked at here, so an instruction in flight always completes
        if (!exec_stall) begin
          if (instr0_q[31:24] == OP_END) state_d = S_HLT;
          else if (jmp_req) begin
            pc_d    = jmp_addr;
            state_d = S_F0;
          end
          else if (!run) state_d = S_HLT;
          else state_d = S_F0;
        end
      end
      default: state_d = S_HLT;
    endcase
`ifdef FETCH_BOUNDS_EN
    // Every fetch state entry (including jump targets) is checked against the code size
    if ((state_d == S_F0 || state_d == S_F1) && ({1'b0, pc_d} >= CODE_LIM)) begin
      state_d = S_HLT;
      fault_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HLT;
      pc_q     <= '0;
      instr0_q <= 32'd0;
      instr1_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
    end
  end

`ifdef FETCH_BOUNDS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`endif

  // Memory is always addressed by pc; reads outside fetch states are simply ignored
  assign mem_addr      = pc_q;
  assign pc            = pc_q;
  assign instr0        = instr0_q;
  assign instr1        = instr1_q;
  assign current_state = {1'b0, state_q};
  assign halted        = (state_q == S_HLT) || (state_q > S_EXEC);
  assign fault         = flt;

endmodule
